// File: rtl/ahb_pixel_fifo_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pixel_fifo_slave_if
// Brief    : AHB-Lite slave bus plus per-channel pixel stream and IRQ bundle
// Revision : 1.0
// ============================================================================
interface ahb_pixel_fifo_slave_if #(
    parameter int NCH    = 2,
    parameter int DATA_W = 8
);
    logic                    HSEL;
    logic [7:0]              HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [31:0]             HWDATA;
    logic                    HREADY;
    logic [31:0]             HRDATA;
    logic                    HREADYOUT;
    logic                    HRESP;
    logic [NCH-1:0]          PIX_VALID;
    logic [NCH*DATA_W-1:0]   PIX_DATA;
    logic                    IRQ;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  PIX_VALID, PIX_DATA,
        output HRDATA, HREADYOUT, HRESP, IRQ
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output PIX_VALID, PIX_DATA,
        input  HRDATA, HREADYOUT, HRESP, IRQ
    );
endinterface
`default_nettype wire

// File: rtl/ahb_pixel_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pixel_fifo_slave
// Brief    : Zero-wait AHB-Lite slave with per-channel pixel FIFOs and IRQ
// Revision : 1.0
// ============================================================================
module ahb_pixel_fifo_slave #(
    parameter int NCH    = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  wire logic               SYSCLK,
    input  wire logic               NSYSRESET,
    ahb_pixel_fifo_slave_if.slave   bus
);
    localparam int                 c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [4:0]         c_NCH_LIM = 5'(NCH);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_THRESH  = c_CNT_W'(THRESH);

    // Address-phase decode
    logic       w_xfer;
    logic       w_rd;
    logic       w_hit;
    logic [3:0] w_ach;
    logic [1:0] w_aoff;

    assign w_xfer = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_rd   = w_xfer & ~bus.HWRITE;
    assign w_ach  = bus.HADDR[7:4];
    assign w_aoff = bus.HADDR[3:2];
    assign w_hit  = ({1'b0, w_ach} < c_NCH_LIM);

    // Write address held over into the data phase
    logic       r_wr_pend;
    logic [3:0] r_wr_ch;
    logic [1:0] r_wr_off;

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            r_wr_pend <= 1'b0;
            r_wr_ch   <= '0;
            r_wr_off  <= '0;
        end else begin
            r_wr_pend <= w_xfer & bus.HWRITE & w_hit;
            r_wr_ch   <= w_ach;
            r_wr_off  <= w_aoff;
        end
    end

    logic [31:0]    w_data_rd [NCH];
    logic [31:0]    w_stat_rd [NCH];
    logic [31:0]    w_ctrl_rd [NCH];
    logic [NCH-1:0] w_irq_c;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            localparam logic [3:0] c_IDX = 4'(c);

            logic [DATA_W-1:0]  r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_wp;
            logic [c_PTR_W-1:0] r_rp;
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_en;
            logic               r_ien;
            logic               r_ovf;
            logic               r_unf;

            logic              w_sel_stat;
            logic              w_sel_ctrl;
            logic              w_flush;
            logic              w_empty;
            logic              w_empty_eff;
            logic              w_full;
            logic              w_rd_data;
            logic              w_push;
            logic              w_pop;
            logic              w_wr_ok;
            logic              w_ovf_set;
            logic              w_ovf_clr;
            logic              w_unf_set;
            logic              w_unf_clr;
            logic [8:0]        w_cnt9;
            logic [DATA_W-1:0] w_pix;

            assign w_sel_stat  = r_wr_pend & (r_wr_ch == c_IDX) & (r_wr_off == 2'd1);
            assign w_sel_ctrl  = r_wr_pend & (r_wr_ch == c_IDX) & (r_wr_off == 2'd2);
            assign w_flush     = w_sel_ctrl & bus.HWDATA[1];
            assign w_ovf_clr   = w_sel_stat & bus.HWDATA[18];
            assign w_unf_clr   = w_sel_stat & bus.HWDATA[19];
            assign w_pix       = bus.PIX_DATA[c*DATA_W +: DATA_W];

            // A flush landing this edge makes the FIFO look empty to a same-edge read
            assign w_empty     = (r_cnt == '0);
            assign w_full      = (r_cnt == c_DEPTH);
            assign w_empty_eff = w_empty | w_flush;
            assign w_rd_data   = w_rd & (w_ach == c_IDX) & (w_aoff == 2'd0);
            assign w_pop       = w_rd_data & ~w_empty_eff;
            assign w_push      = bus.PIX_VALID[c] & r_en;
            assign w_wr_ok     = w_push & (~w_full | w_pop) & ~w_flush;
            assign w_ovf_set   = w_push & w_full & ~w_pop & ~w_flush;
            assign w_unf_set   = w_rd_data & w_empty_eff;
            assign w_cnt9      = w_flush ? 9'd0 : 9'(r_cnt);

            assign w_data_rd[c] = w_empty_eff ? 32'd0 : 32'(r_mem[r_rp]);
            assign w_stat_rd[c] = {12'd0, r_unf & ~w_unf_clr, r_ovf & ~w_ovf_clr,
                                   w_full & ~w_flush, w_empty_eff, 7'd0, w_cnt9};
            assign w_ctrl_rd[c] = w_sel_ctrl ? {29'd0, bus.HWDATA[2], 1'b0, bus.HWDATA[0]}
                                             : {29'd0, r_ien, 1'b0, r_en};
            assign w_irq_c[c]   = r_ien & ((r_cnt >= c_THRESH) | r_ovf);

            always_ff @(posedge SYSCLK) begin
                if (!NSYSRESET) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                    r_en  <= 1'b0;
                    r_ien <= 1'b0;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end else begin
                    if (w_sel_ctrl) begin
                        r_en  <= bus.HWDATA[0];
                        r_ien <= bus.HWDATA[2];
                    end
                    // A new event on the same edge outranks a software clear
                    if (w_ovf_set)      r_ovf <= 1'b1;
                    else if (w_ovf_clr) r_ovf <= 1'b0;
                    if (w_unf_set)      r_unf <= 1'b1;
                    else if (w_unf_clr) r_unf <= 1'b0;

                    if (w_flush) begin
                        r_wp  <= '0;
                        r_rp  <= '0;
                        r_cnt <= '0;
                    end else begin
                        if (w_wr_ok) r_wp <= r_wp + c_PTR_W'(1);
                        if (w_pop)   r_rp <= r_rp + c_PTR_W'(1);
                        case ({w_wr_ok, w_pop})
                            2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                            2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                            default: r_cnt <= r_cnt;
                        endcase
                    end
                end
            end

            always_ff @(posedge SYSCLK) begin
                if (NSYSRESET && w_wr_ok) begin
                    r_mem[r_wp] <= w_pix;
                end
            end
        end
    endgenerate

    // Read data is captured at the address-phase edge and held for the data phase
    logic [31:0] w_rdata_nxt;
    logic [31:0] r_hrdata;
    logic        r_irq;

    always_comb begin
        w_rdata_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_ach == 4'(i)) begin
                case (w_aoff)
                    2'd0:    w_rdata_nxt = w_data_rd[i];
                    2'd1:    w_rdata_nxt = w_stat_rd[i];
                    2'd2:    w_rdata_nxt = w_ctrl_rd[i];
                    default: w_rdata_nxt = '0;
                endcase
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            r_hrdata <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_rd) r_hrdata <= w_rdata_nxt;
            r_irq <= |w_irq_c;
        end
    end

    assign bus.HRDATA    = r_hrdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign bus.IRQ       = r_irq;

    logic w_unused;
    assign w_unused = ^{bus.HSIZE, bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};
endmodule
`default_nettype wire

// File: doc/ahb_pixel_fifo_slave.md
Name: ahb_pixel_fifo_slave

Overview:
- Parametrised AHB-Lite slave in the fabric, on the MSS fabric master port (MSSH* bus). Successor to the single fixed-width fabric slave.
- Buffers pixel streams from NCH camera-side channels in per-channel FIFOs.
- Exposes per-channel DATA/STATUS/CTRL registers to the Cortex-M3, with sticky overflow/underflow flags and a threshold interrupt.

Parameters:
NCH, 2, number of pixel channels (1..8)
DATA_W, 8, pixel width in bits (1..32); zero-extended to 32 on reads
DEPTH, 16, FIFO entries per channel; power of two, 2..256
THRESH, 8, fill level (1..DEPTH) at or above which a channel raises its IRQ contribution

Ports:
SYSCLK  in  1  single clock; all logic is rising-edge
NSYSRESET  in  1  synchronous active-low reset
HSEL  in  1  slave select
HADDR  in  8  byte address; bits[1:0] ignored
HTRANS  in  2  transfer type; bit1 set = NONSEQ/SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  ignored; word access only
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready (qualifies address phase)
HRDATA  out  32  read data (data phase)
HREADYOUT  out  1  constant 1 (zero wait states)
HRESP  out  1  constant 0 (OKAY)
PIX_VALID  in  NCH  per-channel push strobe
PIX_DATA  in  NCH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
IRQ  out  1  level interrupt

Behaviour:
- Reset (NSYSRESET low at an edge): all FIFOs empty; count=0; overflow/underflow flags=0; CTRL enable=0; IRQ enable=0; HRDATA=0; latched address-phase state cleared. HREADYOUT=1 and HRESP=0 at all times, including during reset.
- Address map per channel c, base c*16:
  - +0 DATA: RO; read pops one entry.
  - +4 STATUS: [8:0] count, [16] empty, [17] full, [18] overflow, [19] underflow; write 1 to bit 18/19 clears that flag.
  - +8 CTRL: [0] enable, [1] flush (self-clearing, reads 0), [2] irq_en.
  - Addresses >= NCH*16 or offset +12: read 0, writes ignored, OKAY.
- Valid transfer: HSEL & HTRANS[1] & HREADY at an edge.
- Reads: decoded in the address phase. HRDATA is registered at that same edge and held through the data phase. A DATA read pops at that edge. Read latency is one cycle, matching the zero-wait data phase.
  - DATA read while empty: HRDATA=0, no pop, underflow set.
- Writes: address/HWRITE latched at the address-phase edge. HWDATA applied at the next edge, the end of the data phase. Back-to-back write-then-read to the same register returns the new value.
- Push: at each edge where PIX_VALID[c]=1 and enable[c]=1, PIX_DATA slice c is written to the tail.
  - Push while disabled: ignored; no flag set.
  - Push while full with no simultaneous pop: data dropped, overflow set, count stays DEPTH.
- Simultaneous push and pop on the same edge (including when full): both occur; count unchanged; no overflow. When empty, the pop is decided on the pre-edge state, so underflow is set, HRDATA=0 and the pushed word is stored.
- Flush: a CTRL write with bit1=1 empties the FIFO at the applying edge. Flush wins over a same-edge push or pop. Flags are not cleared by flush.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is a separate log2(DEPTH)+1-bit register, range 0..DEPTH.
- IRQ is registered, asserting one edge after the condition becomes true: IRQ = OR over c of irq_en[c] & ((count[c] >= THRESH) | overflow[c]).
- Reset asserted mid-transfer aborts the pending data phase; no pop or write takes effect at that edge.

Test Plan:
- Reset, then read STATUS ch0 (0x04) -> 0x0001_0000 (empty, count 0). IRQ=0; HREADYOUT=1 throughout.
- Enable ch1 (write 0x18 = 0x1); push 0x11,0x22,0x33 on ch1; read 0x10 three times -> 0x11, 0x22, 0x33 on consecutive data phases. Fourth read -> 0 and STATUS ch1 bit19 set.
- Enable ch0 with irq_en (0x08 = 0x5); push DEPTH+1 pixels -> STATUS count=16, full=1, overflow=1. IRQ rose one edge after count reached 8. Write 0x04 = 0x40000 -> overflow clears.
- FIFO full; push and DATA read on the same edge -> count stays 16, overflow stays 0, oldest word returned. Repeat for 40 cycles to exercise pointer wrap; data order is preserved.
- Flush during a concurrent push (CTRL = 0x3 applied on the same edge PIX_VALID=1) -> count=0, empty=1.
- Read 0x0C and 0x40 (NCH=2) -> 0, HRESP=0. Assert NSYSRESET for one cycle mid read data phase -> all registers return to reset values and no pop occurs.
